// File: rtl/cache_arb_pkg.sv
// Shared state encoding, policy constants and default widths for the
// cache-line arbiter and its picker.
package cache_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } arb_state_e;

  localparam logic ARB_MODE_FIXED = 1'b0;
  localparam logic ARB_MODE_RR    = 1'b1;

  localparam int DEF_LINE_W    = 128;
  localparam int DEF_ADDR_BITS = 15;

endpackage

// File: rtl/arb_rr_picker.sv
// Combinational one-hot picker: lowest-index candidate in fixed mode, first
// candidate at or after ptr (wrapping) in round-robin mode.
module arb_rr_picker
  import cache_arb_pkg::*;
#(
  parameter int N = 2
)(
  input  logic [N-1:0]         cand,
  input  logic [$clog2(N)-1:0] ptr,
  input  logic                 mode,
  output logic [N-1:0]         grant,
  output logic [$clog2(N)-1:0] idx,
  output logic                 any
);

  localparam int IDX_W = $clog2(N);

  int pick_start;
  int pick_pos;

  always_comb begin
    grant      = '0;
    idx        = '0;
    any        = 1'b0;
    pick_pos   = 0;
    pick_start = (mode == ARB_MODE_RR) ? int'(ptr) : 0;
    // An out-of-range pointer (non power-of-two N) falls back to index 0.
    if (pick_start >= N) pick_start = 0;
    for (int i = 0; i < N; i++) begin
      pick_pos = pick_start + i;
      if (pick_pos >= N) pick_pos = pick_pos - N;
      if (!any && cand[pick_pos]) begin
        any             = 1'b1;
        grant[pick_pos] = 1'b1;
        idx             = IDX_W'(pick_pos);
      end
    end
  end

endmodule

// File: rtl/cache_line_arbiter.sv
// Arbitrates NUM_CH cache/crypto channels onto the single-port line BRAM,
// holding the grant for a whole access. Optional watchdog: CACHE_ARB_TIMEOUT_EN.
module cache_line_arbiter
  import cache_arb_pkg::*;
#(
  parameter int NUM_CH         = 2,
  parameter int ADDR_BITS      = DEF_ADDR_BITS,
  parameter int LINE_W         = DEF_LINE_W,
  parameter int RR_MODE        = 0,
  parameter int TIMEOUT_CYCLES = 255
)(
  input  logic                        sys_clock,
  input  logic                        reset,
  input  logic [NUM_CH-1:0]           ch_req,
  input  logic [NUM_CH-1:0]           ch_write,
  input  logic [NUM_CH*ADDR_BITS-1:0] ch_addr,
  input  logic [NUM_CH*LINE_W-1:0]    ch_wdata,
  output logic [LINE_W-1:0]           ch_rdata,
  output logic [NUM_CH-1:0]           ch_rdy,
  output logic                        mem_req,
  output logic                        mem_write,
  output logic [ADDR_BITS-1:0]        mem_addr,
  output logic [LINE_W-1:0]           mem_wdata,
  input  logic [LINE_W-1:0]           mem_rdata,
  input  logic                        mem_valid,
  output logic [NUM_CH-1:0]           grant_o,
  output logic                        busy_o,
  output logic                        timeout_o
);

  localparam int   IDX_W    = $clog2(NUM_CH);
  localparam logic ARB_MODE = (RR_MODE != 0) ? ARB_MODE_RR : ARB_MODE_FIXED;

  if (NUM_CH < 2 || NUM_CH > 8 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("cache_line_arbiter: NUM_CH must be 2..8 and TIMEOUT_CYCLES >= 1");
  end

  // Handshake: a channel raises ch_req (level) with write/addr/wdata and holds
  // it until its one-cycle ch_rdy pulse; ch_rdata is valid in that same cycle.
  // Fields are latched at grant, so later changes never affect the access.
  arb_state_e        state;
  logic [IDX_W-1:0]  owner;
  logic [IDX_W-1:0]  rr_ptr;
  logic [NUM_CH-1:0] served_mask;
  logic [NUM_CH-1:0] cand;
  logic [NUM_CH-1:0] pick_grant;
  logic [IDX_W-1:0]  pick_idx;
  logic              pick_any;
  logic              sel_write;
  logic [ADDR_BITS-1:0] sel_addr;
  logic [LINE_W-1:0]    sel_wdata;

`ifdef CACHE_ARB_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] wait_cnt;
`endif

  // The previous owner is hidden for one IDLE cycle so a registered requester
  // whose req lags its ch_rdy by a cycle is not served twice.
  assign cand = ch_req & ~served_mask;

  arb_rr_picker #(.N(NUM_CH)) u_picker (
    .cand  (cand),
    .ptr   (rr_ptr),
    .mode  (ARB_MODE),
    .grant (pick_grant),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  always_comb begin
    sel_write = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (pick_grant[i]) begin
        sel_write = ch_write[i];
        sel_addr  = ch_addr[i*ADDR_BITS +: ADDR_BITS];
        sel_wdata = ch_wdata[i*LINE_W +: LINE_W];
      end
    end
  end

  always_ff @(posedge sys_clock) begin
    if (reset) begin
      state       <= IDLE;
      owner       <= '0;
      rr_ptr      <= '0;
      served_mask <= '0;
      ch_rdata    <= '0;
      ch_rdy      <= '0;
      mem_req     <= 1'b0;
      mem_write   <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      grant_o     <= '0;
      busy_o      <= 1'b0;
      timeout_o   <= 1'b0;
`ifdef CACHE_ARB_TIMEOUT_EN
      wait_cnt    <= '0;
`endif
    end else begin
      ch_rdy    <= '0;
      timeout_o <= 1'b0;
      case (state)
        IDLE: begin
          served_mask <= '0;
          if (pick_any) begin
            owner     <= pick_idx;
            grant_o   <= pick_grant;
            mem_req   <= 1'b1;
            mem_write <= sel_write;
            mem_addr  <= sel_addr;
            mem_wdata <= sel_wdata;
            busy_o    <= 1'b1;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          // A completion strobe during ISSUE cannot belong to this access.
          state <= WAIT;
`ifdef CACHE_ARB_TIMEOUT_EN
          wait_cnt <= '0;
`endif
        end
        WAIT: begin
          if (mem_valid) begin
            ch_rdata  <= mem_rdata;
            ch_rdy    <= grant_o;
            mem_req   <= 1'b0;
            mem_write <= 1'b0;
            state     <= DONE;
          end
`ifdef CACHE_ARB_TIMEOUT_EN
          else if (wait_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
            ch_rdata  <= '0;
            ch_rdy    <= grant_o;
            timeout_o <= 1'b1;
            mem_req   <= 1'b0;
            mem_write <= 1'b0;
            state     <= DONE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
`endif
        end
        DONE: begin
          served_mask <= grant_o;
          if (ARB_MODE == ARB_MODE_RR) begin
            rr_ptr <= (owner == IDX_W'(NUM_CH - 1)) ? '0 : owner + 1'b1;
          end
          grant_o <= '0;
          busy_o  <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_line_arbiter.sv
// Directed bench for cache_line_arbiter: a 2-channel fixed-priority instance,
// a 4-channel round-robin instance, and a watchdog instance when enabled.
module tb_cache_line_arbiter;

  localparam int AW = 15;
  localparam int LW = 128;

  // ---------------- clock / reset ----------------
  logic sys_clock = 1'b0;
  logic reset;
  always #5 sys_clock = ~sys_clock;

  // ---------------- instance a: 2 channels, fixed priority ----------------
  logic [1:0]      a_req, a_write, a_rdy, a_grant;
  logic [2*AW-1:0] a_addr;
  logic [2*LW-1:0] a_wdata;
  logic [LW-1:0]   a_rdata, a_mem_wdata, a_mem_rdata;
  logic [AW-1:0]   a_mem_addr;
  logic            a_mem_req, a_mem_write, a_mem_valid, a_busy, a_timeout;

  cache_line_arbiter #(.NUM_CH(2), .ADDR_BITS(AW), .LINE_W(LW), .RR_MODE(0)) dut (
    .sys_clock (sys_clock), .reset (reset),
    .ch_req (a_req), .ch_write (a_write), .ch_addr (a_addr), .ch_wdata (a_wdata),
    .ch_rdata (a_rdata), .ch_rdy (a_rdy),
    .mem_req (a_mem_req), .mem_write (a_mem_write), .mem_addr (a_mem_addr),
    .mem_wdata (a_mem_wdata), .mem_rdata (a_mem_rdata), .mem_valid (a_mem_valid),
    .grant_o (a_grant), .busy_o (a_busy), .timeout_o (a_timeout)
  );

  // ---------------- instance b: 4 channels, round robin ----------------
  logic [3:0]      b_req, b_write, b_rdy, b_grant;
  logic [4*AW-1:0] b_addr;
  logic [4*LW-1:0] b_wdata;
  logic [LW-1:0]   b_rdata, b_mem_wdata, b_mem_rdata;
  logic [AW-1:0]   b_mem_addr;
  logic            b_mem_req, b_mem_write, b_mem_valid, b_busy, b_timeout;

  cache_line_arbiter #(.NUM_CH(4), .ADDR_BITS(AW), .LINE_W(LW), .RR_MODE(1)) dut_rr (
    .sys_clock (sys_clock), .reset (reset),
    .ch_req (b_req), .ch_write (b_write), .ch_addr (b_addr), .ch_wdata (b_wdata),
    .ch_rdata (b_rdata), .ch_rdy (b_rdy),
    .mem_req (b_mem_req), .mem_write (b_mem_write), .mem_addr (b_mem_addr),
    .mem_wdata (b_mem_wdata), .mem_rdata (b_mem_rdata), .mem_valid (b_mem_valid),
    .grant_o (b_grant), .busy_o (b_busy), .timeout_o (b_timeout)
  );

`ifdef CACHE_ARB_TIMEOUT_EN
  // ---------------- instance c: watchdog, BRAM never answers ----------------
  logic [1:0]      c_req, c_write, c_rdy, c_grant;
  logic [2*AW-1:0] c_addr;
  logic [2*LW-1:0] c_wdata;
  logic [LW-1:0]   c_rdata, c_mem_wdata, c_mem_rdata;
  logic [AW-1:0]   c_mem_addr;
  logic            c_mem_req, c_mem_write, c_mem_valid, c_busy, c_timeout;

  cache_line_arbiter #(.NUM_CH(2), .ADDR_BITS(AW), .LINE_W(LW), .RR_MODE(0),
                       .TIMEOUT_CYCLES(8)) dut_to (
    .sys_clock (sys_clock), .reset (reset),
    .ch_req (c_req), .ch_write (c_write), .ch_addr (c_addr), .ch_wdata (c_wdata),
    .ch_rdata (c_rdata), .ch_rdy (c_rdy),
    .mem_req (c_mem_req), .mem_write (c_mem_write), .mem_addr (c_mem_addr),
    .mem_wdata (c_mem_wdata), .mem_rdata (c_mem_rdata), .mem_valid (c_mem_valid),
    .grant_o (c_grant), .busy_o (c_busy), .timeout_o (c_timeout)
  );
`endif

  // ---------------- BRAM responders ----------------
  // mem_valid is raised resp_lat cycles after the first cycle mem_req is seen.
  logic          resp_en;
  int            resp_lat;
  logic [LW-1:0] resp_data;

  initial begin
    int age;
    age = -1;
    a_mem_valid = 1'b0;
    a_mem_rdata = '0;
    forever begin
      @(negedge sys_clock);
      a_mem_valid = 1'b0;
      if (!a_mem_req) age = -1;
      else begin
        age++;
        if (resp_en && age == resp_lat) begin
          a_mem_valid = 1'b1;
          a_mem_rdata = resp_data;
        end
      end
    end
  end

  initial begin
    int age;
    age = -1;
    b_mem_valid = 1'b0;
    b_mem_rdata = {4{32'h0BAD_CAFE}};
    forever begin
      @(negedge sys_clock);
      b_mem_valid = 1'b0;
      if (!b_mem_req) age = -1;
      else begin
        age++;
        if (age == 1) b_mem_valid = 1'b1;
      end
    end
  end

  // ---------------- scoreboard ----------------
  int n_pass  = 0;
  int n_total = 0;
  logic [3:0] exp_q[$];

  task automatic check(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Returns the number of negedges until a ch_rdy pulse (0 on expiry).
  task automatic wait_rdy(input string tag, input int which, output int lat);
    logic hit;
    hit = 1'b0;
    lat = 0;
    for (int i = 1; i <= 64; i++) begin
      @(negedge sys_clock);
      hit = (which == 0) ? (a_rdy != 2'b00) : (b_rdy != 4'b0000);
      if (hit) begin
        lat = i;
        break;
      end
    end
    if (lat == 0) check({tag, "_bound"}, LW'(hit), LW'(1'b1));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int lat;
    logic [1:0] seen;

    reset = 1'b1;
    a_req = '0; a_write = '0; a_addr = '0; a_wdata = '0;
    b_req = '0; b_write = '0; b_addr = '0; b_wdata = '0;
    resp_en = 1'b1; resp_lat = 2; resp_data = '0;
`ifdef CACHE_ARB_TIMEOUT_EN
    c_req = '0; c_write = '0; c_addr = '0; c_wdata = '0;
    c_mem_valid = 1'b0; c_mem_rdata = '1;
`endif

    // Reset state
    repeat (3) @(negedge sys_clock);
    check("rst_mem_req", LW'(a_mem_req), LW'(1'b0));
    check("rst_grant",   LW'(a_grant),   LW'(2'b00));
    check("rst_busy",    LW'(a_busy),    LW'(1'b0));
    check("rst_rdy",     LW'(a_rdy),     LW'(2'b00));
    check("rst_rdata",   a_rdata,        LW'(0));
    check("rst_addr",    LW'(a_mem_addr), LW'(0));
    check("rst_rr_grant", LW'(b_grant),  LW'(4'b0000));
    reset = 1'b0;

    // 1. Single read, k = 2
    repeat (2) @(negedge sys_clock);
    a_req = 2'b01; a_write = 2'b00; a_addr[0 +: AW] = 15'h0010;
    resp_lat = 2; resp_data = {16{8'hA5}};
    @(negedge sys_clock);
    check("t1_mem_req", LW'(a_mem_req),   LW'(1'b1));
    check("t1_grant",   LW'(a_grant),     LW'(2'b01));
    check("t1_addr",    LW'(a_mem_addr),  LW'(15'h0010));
    check("t1_write",   LW'(a_mem_write), LW'(1'b0));
    check("t1_busy",    LW'(a_busy),      LW'(1'b1));
    wait_rdy("t1", 0, lat);
    a_req = 2'b00;
    check("t1_lat",     LW'(lat),       LW'(3));
    check("t1_rdy",     LW'(a_rdy),     LW'(2'b01));
    check("t1_rdata",   a_rdata,        {16{8'hA5}});
    check("t1_timeout", LW'(a_timeout), LW'(1'b0));
    @(negedge sys_clock);
    check("t1_rdy_pulse", LW'(a_rdy),   LW'(2'b00));
    check("t1_idle",    LW'(a_busy),    LW'(1'b0));
    check("t1_grant0",  LW'(a_grant),   LW'(2'b00));
    check("t1_hold",    a_rdata,        {16{8'hA5}});

    // 2. Fixed contention; ch0 keeps requesting throughout
    repeat (2) @(negedge sys_clock);
    resp_lat = 1;
    a_addr = {15'h0200, 15'h0100};
    exp_q.push_back(4'b0001); exp_q.push_back(4'b0010); exp_q.push_back(4'b0001);
    a_req = 2'b11;
    wait_rdy("t2a", 0, lat);
    check("t2_lat0",   LW'(lat),   LW'(3));
    check("t2_order0", LW'(a_rdy), LW'(exp_q.pop_front()));
    wait_rdy("t2b", 0, lat);
    check("t2_turn1",  LW'(lat),   LW'(4));
    check("t2_order1", LW'(a_rdy), LW'(exp_q.pop_front()));
    a_req = 2'b01;
    wait_rdy("t2c", 0, lat);
    check("t2_turn2",  LW'(lat),   LW'(4));
    check("t2_order2", LW'(a_rdy), LW'(exp_q.pop_front()));
    a_req = 2'b00;

    // 4. Write stability and no double service of a lagging requester
    repeat (2) @(negedge sys_clock);
    resp_lat = 3;
    a_req = 2'b10; a_write = 2'b10;
    a_addr[AW +: AW] = 15'h1FF0; a_wdata[LW +: LW] = {8{16'h1234}};
    @(negedge sys_clock);
    check("t4_grant", LW'(a_grant),     LW'(2'b10));
    check("t4_write", LW'(a_mem_write), LW'(1'b1));
    a_addr[AW +: AW] = 15'h0AAA; a_wdata[LW +: LW] = '1; a_write = 2'b00;
    @(negedge sys_clock);
    check("t4_addr_hold",  LW'(a_mem_addr),  LW'(15'h1FF0));
    check("t4_wdata_hold", a_mem_wdata,      {8{16'h1234}});
    check("t4_write_hold", LW'(a_mem_write), LW'(1'b1));
    check("t4_req_hold",   LW'(a_mem_req),   LW'(1'b1));
    wait_rdy("t4", 0, lat);
    check("t4_rdy", LW'(a_rdy), LW'(2'b10));
    @(negedge sys_clock);
    @(negedge sys_clock);
    a_req = 2'b00;
    check("t4_no_regrant", LW'(a_busy), LW'(1'b0));
    @(negedge sys_clock);
    check("t4_no_mem_req", LW'(a_mem_req), LW'(1'b0));

    // 5. Reset while waiting on the BRAM
    repeat (2) @(negedge sys_clock);
    resp_en = 1'b0;
    a_req = 2'b01; a_addr[0 +: AW] = 15'h0333;
    repeat (2) @(negedge sys_clock);
    check("t5_waiting", LW'(a_mem_req), LW'(1'b1));
    reset = 1'b1; a_req = 2'b00;
    @(negedge sys_clock);
    reset = 1'b0;
    check("t5_mem_req", LW'(a_mem_req), LW'(1'b0));
    check("t5_grant",   LW'(a_grant),   LW'(2'b00));
    check("t5_busy",    LW'(a_busy),    LW'(1'b0));
    check("t5_rdata",   a_rdata,        LW'(0));
    seen = a_rdy;
    repeat (3) begin
      @(negedge sys_clock);
      seen = seen | a_rdy;
    end
    check("t5_no_rdy", LW'(seen), LW'(2'b00));
    resp_en = 1'b1; resp_lat = 1; resp_data = {4{32'hCAFE_F00D}};
    a_req = 2'b01;
    wait_rdy("t5", 0, lat);
    a_req = 2'b00;
    check("t5_fresh_lat",   LW'(lat),   LW'(3));
    check("t5_fresh_rdy",   LW'(a_rdy), LW'(2'b01));
    check("t5_fresh_rdata", a_rdata,    {4{32'hCAFE_F00D}});

    // 3. Round robin over four channels, then a wrap-around pick
    repeat (2) @(negedge sys_clock);
    exp_q.push_back(4'b0001); exp_q.push_back(4'b0010); exp_q.push_back(4'b0100);
    exp_q.push_back(4'b1000); exp_q.push_back(4'b0001);
    b_req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      wait_rdy("rr", 1, lat);
      if (k == 1) check("rr_turn", LW'(lat), LW'(4));
      check($sformatf("rr_grant%0d", k), LW'(b_rdy), LW'(exp_q.pop_front()));
    end
    b_req = 4'b0000;
    repeat (2) @(negedge sys_clock);
    exp_q.push_back(4'b1000); exp_q.push_back(4'b0001);
    b_req = 4'b1001;
    for (int k = 0; k < 2; k++) begin
      wait_rdy("rr_wrap", 1, lat);
      check($sformatf("rr_wrap%0d", k), LW'(b_rdy), LW'(exp_q.pop_front()));
      b_req = b_req & ~b_rdy;
    end
    b_req = 4'b0000;

`ifdef CACHE_ARB_TIMEOUT_EN
    // 6. Watchdog: 8 cycles after WAIT entry with no mem_valid
    repeat (2) @(negedge sys_clock);
    c_req = 2'b10;
    lat = 0;
    for (int i = 1; i <= 64; i++) begin
      @(negedge sys_clock);
      if (c_rdy != 2'b00) begin
        lat = i;
        break;
      end
    end
    c_req = 2'b00;
    check("to_lat",     LW'(lat),       LW'(10));
    check("to_rdy",     LW'(c_rdy),     LW'(2'b10));
    check("to_pulse",   LW'(c_timeout), LW'(1'b1));
    check("to_rdata",   c_rdata,        LW'(0));
    check("to_mem_req", LW'(c_mem_req), LW'(1'b0));
    @(negedge sys_clock);
    check("to_idle",    LW'(c_busy),    LW'(1'b0));
    check("to_once",    LW'(c_timeout), LW'(1'b0));
`endif

    repeat (2) @(negedge sys_clock);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
